// File: rtl/xalu_muldiv.sv
// Multiply/divide unit for the E stage: holds HI/LO, runs MULT/MULTU/DIV/DIVU over a fixed busy window.
// Latency: MULT* = MULT_CYCLES, DIV* = DIV_CYCLES busy cycles; MTHI/MTLO write on the accepting edge.
// Backpressure: start is ignored while busy; the hazard unit stalls dependents on start|busy.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   A, B               forwarded RS/RT operands (latched when a mul/div is accepted)
//   XALU_OP, start     operation code and its qualifier
//   HILO_sel           read select for XALUOUT (0 = LO, 1 = HI)
//   XALUOUT            registered HI or LO
//   busy               multi-cycle operation in progress
module xalu_muldiv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  XALU_OP,
  input  logic        start,
  input  logic        HILO_sel,
  output logic [31:0] XALUOUT,
  output logic        busy
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   opa, opb;
  logic [2:0]    op_l;
  logic [31:0]   hi, lo;

  logic accept, start_md, done;

  // Requests are only taken while idle; op 0 and 7 are no-ops.
  assign accept   = start && (state == IDLE) && (XALU_OP != 3'd0) && (XALU_OP != 3'd7);
  assign start_md = accept && (XALU_OP >= OP_MULT) && (XALU_OP <= OP_DIVU);
  // Counter holds N after acceptance, so the N-th busy edge is the one that sees 1.
  assign done     = (state == BUSY) && (cnt == CW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_md) state_nxt = BUSY;
      BUSY:    if (done)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == BUSY);
  end

  assign XALUOUT = HILO_sel ? hi : lo;

  // Datapath on the latched operands. Signed multiply by sign-extending to 64 bits;
  // signed divide through magnitudes so 0x80000000 / -1 needs no special case.
  logic [63:0] ea, eb, product;
  logic        sdiv, neg_a, neg_b;
  logic [31:0] mag_a, mag_b, dvsr, uq, ur, quot, rem;

  always_comb begin
    ea      = {{32{(op_l == OP_MULT) & opa[31]}}, opa};
    eb      = {{32{(op_l == OP_MULT) & opb[31]}}, opb};
    product = ea * eb;

    sdiv  = (op_l == OP_DIV);
    neg_a = sdiv & opa[31];
    neg_b = sdiv & opb[31];
    mag_a = neg_a ? (32'd0 - opa) : opa;
    mag_b = neg_b ? (32'd0 - opb) : opb;
    dvsr  = (mag_b == 32'd0) ? 32'd1 : mag_b;  // zero divisor result is discarded anyway
    uq    = mag_a / dvsr;
    ur    = mag_a % dvsr;
    quot  = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    rem   = neg_a ? (32'd0 - ur) : ur;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      opa  <= '0;
      opb  <= '0;
      op_l <= '0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      if (start_md) begin
        cnt  <= (XALU_OP <= OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        opa  <= A;
        opb  <= B;
        op_l <= XALU_OP;
      end else if (state == BUSY) begin
        cnt <= cnt - CW'(1);
      end

      if (accept && (XALU_OP == OP_MTHI)) hi <= A;
      if (accept && (XALU_OP == OP_MTLO)) lo <= A;

      if (done) begin
        if (op_l == OP_MULT || op_l == OP_MULTU) begin
          hi <= product[63:32];
          lo <= product[31:0];
        end else if (opb != 32'd0) begin
          hi <= rem;
          lo <= quot;
        end
      end
    end
  end

endmodule

// File: tb/tb_xalu_muldiv.sv
module tb_xalu_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  XALU_OP;
  logic        start;
  logic        HILO_sel;
  logic [31:0] XALUOUT;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  xalu_muldiv #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .XALU_OP(XALU_OP),
    .start(start), .HILO_sel(HILO_sel), .XALUOUT(XALUOUT), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(output logic [31:0] h, output logic [31:0] l);
    HILO_sel = 1'b1; #1; h = XALUOUT;
    HILO_sel = 1'b0; #1; l = XALUOUT;
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    logic [31:0] h, l;
    rd(h, l);
    chk({tag, ".hi"}, h, eh);
    chk({tag, ".lo"}, l, el);
  endtask

  // Presents a request for one edge, then scrambles operands to prove they were latched.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; XALU_OP = op; A = a; B = b;
    step();
    start = 1'b0; XALU_OP = 3'd0; A = 32'hDEADBEEF; B = 32'h0BADF00D;
  endtask

  // Counts cycles with busy high, bounded.
  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      step();
    end
    if (n >= 50) chk({tag, ".timeout"}, 32'(n), 32'd0);
  endtask

  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int ncyc,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    issue(op, a, b);
    wait_idle(tag, n);
    chk({tag, ".busy_cycles"}, 32'(n), 32'(ncyc));
    check_hilo(tag, eh, el);
  endtask

  initial begin
    int n;
    logic [31:0] h, l;
    reset = 1'b1; start = 1'b0; XALU_OP = 3'd0; A = '0; B = '0; HILO_sel = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("reset.busy", 32'(busy), 32'd0);
    check_hilo("reset", 32'h0, 32'h0);

    run_md("mult_neg",  3'd1, 32'hFFFFFFFD, 32'd5,        5,  32'hFFFFFFFF, 32'hFFFFFFF1);
    run_md("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001);
    run_md("div_neg",   3'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("divu",      3'd4, 32'h0000000F, 32'd4,        10, 32'h00000003, 32'h00000003);
    run_md("divu_zero", 3'd4, 32'h00001234, 32'd0,        10, 32'h00000003, 32'h00000003);
    run_md("div_ovf",   3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
    run_md("div_mixed", 3'd3, 32'd100,      32'hFFFFFFF9, 10, 32'h00000002, 32'hFFFFFFF2);

    // Reserved/none ops with start are ignored.
    issue(3'd7, 32'h55555555, 32'h1);
    chk("op7.busy", 32'(busy), 32'd0);
    issue(3'd0, 32'h55555555, 32'h1);
    check_hilo("op_ignored", 32'h00000002, 32'hFFFFFFF2);

    // MULT with start pulses for MTHI and DIV during the busy window.
    issue(3'd1, 32'd7, 32'd6);
    chk("mult_win.busy1", 32'(busy), 32'd1);
    check_hilo("mult_win.old", 32'h00000002, 32'hFFFFFFF2);
    step();
    start = 1'b1; XALU_OP = 3'd5; A = 32'h12345678;
    step();
    start = 1'b1; XALU_OP = 3'd3; A = 32'd9; B = 32'd3;
    step();
    start = 1'b0; XALU_OP = 3'd0;
    check_hilo("mult_win.mid", 32'h00000002, 32'hFFFFFFF2);
    wait_idle("mult_win", n);
    chk("mult_win.busy_cycles", 32'(n + 3), 32'd5);
    check_hilo("mult_win", 32'h00000000, 32'd42);

    // MTHI then MTLO while idle: one-edge writes, no busy.
    issue(3'd5, 32'h11112222, 32'h0);
    chk("mthi.busy", 32'(busy), 32'd0);
    issue(3'd6, 32'hCAFEBABE, 32'h0);
    chk("mtlo.busy", 32'(busy), 32'd0);
    check_hilo("mtlo", 32'h11112222, 32'hCAFEBABE);

    // Reset in the 3rd busy cycle of a DIV aborts it.
    issue(3'd3, 32'd100, 32'd7);
    step(); step();
    chk("abort.busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort.busy", 32'(busy), 32'd0);
    check_hilo("abort", 32'h0, 32'h0);
    for (int i = 0; i < 12; i++) step();
    chk("abort.late_busy", 32'(busy), 32'd0);
    check_hilo("abort.late", 32'h0, 32'h0);

    // Accept again right after an abort.
    run_md("post_abort", 3'd2, 32'h00010000, 32'h00010000, 5, 32'h00000001, 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xalu_muldiv.md
Name: xalu_muldiv

Overview:
Multiply/divide unit in the E stage of the 5-stage MIPS pipeline. It produces the XALUOUT value that is carried through M and W. In M, that value feeds the D-stage forwarding muxes. In W, it feeds the write-back data mux.
- Holds the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU as multi-cycle operations and MTHI/MTLO as single-cycle writes.
- Reports busy to the hazard unit so that dependent MF*/MT*/mul/div instructions stall in D.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, number of busy cycles for DIV/DIVU (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- A  in  32  forwarded RS operand in E
- B  in  32  forwarded RT operand in E
- XALU_OP  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved
- start  in  1  qualifies XALU_OP for the current E instruction
- HILO_sel  in  1  read select: 0 = LO, 1 = HI
- XALUOUT  out  32  HILO_sel ? HI : LO, combinational from the registers
- busy  out  1  multi-cycle operation in progress

Behaviour:
- One clock: clk. Reset is synchronous and active-high on the port reset, sampled only at the rising edge of clk.
- On reset: HI=0, LO=0, busy=0, internal counter=0, pending results discarded. XALUOUT=0 on the first cycle after reset.
- Reset during BUSY aborts the operation. HI/LO become 0 and do not receive the aborted result.
- States:
  - IDLE (busy=0)
  - BUSY (busy=1, counter counts down)
- Acceptance: a request is accepted at edge t iff start=1, busy=0, and XALU_OP is in 1..6.
  - start while busy=1 is ignored. This includes MTHI/MTLO; the hazard unit must stall on start|busy.
  - XALU_OP 0 or 7 with start=1 is ignored.
- MULT/MULTU/DIV/DIVU accepted at edge t:
  - Operands are latched at edge t; later changes on A/B have no effect.
  - Counter is loaded with N (MULT_CYCLES or DIV_CYCLES), and the state goes to BUSY.
  - busy=1 for cycles t+1 .. t+N.
  - At edge t+N: HI/LO are updated, busy returns to 0, and the state goes to IDLE.
  - A new start may be accepted at edge t+N+1 at the earliest, i.e. in the first cycle after busy falls.
- Multiply: 64-bit product {HI,LO}.
  - MULT: A and B are signed 32-bit.
  - MULTU: A and B are unsigned.
- Divide: LO=quotient, HI=remainder.
  - DIV is signed. The quotient truncates toward zero; the remainder takes the sign of the dividend.
  - DIVU is unsigned.
  - Divide by zero (B=0): still goes busy for DIV_CYCLES, then HI/LO are left unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0x00000000.
- MTHI/MTLO accepted at edge t: HI (resp. LO) ← A at edge t. No busy cycle. The other register is unchanged.
- XALUOUT shows the registered values only.
  - During BUSY it shows the old HI/LO.
  - The new value appears in the cycle after the completing edge.
- The internal product/quotient datapath may be combinational on the latched operands or iterative. The visible timing must match the rules above exactly.

Test Plan:
- MULT A=0xFFFFFFFD (−3), B=5 -> busy high for exactly 5 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFF1. XALUOUT with HILO_sel=0 shows 0xFFFFFFF1 the cycle after busy falls.
- MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- DIV A=0xFFFFFFF9 (−7), B=2 -> busy for 10 cycles. Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=0x0000000F, B=4 -> LO=3, HI=3. Then DIVU with B=0 -> busy for 10 cycles, HI/LO still 3/3.
- During a MULT busy window, pulse start with MTHI A=0x12345678 and with DIV -> both ignored. The MULT result lands on schedule. Then MTLO A=0xCAFEBABE while idle -> LO updated next cycle with no busy, HI unchanged.
- Assert reset in the 3rd busy cycle of a DIV -> next cycle busy=0, HI=LO=0, XALUOUT=0, and no late write occurs at the original completion edge.
